// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: elastic pipeline stage register with a valid/ready handshake.
// Sits between CPU pipeline stages and carries a WIDTH-bit payload. It never
// drops or duplicates a payload under backpressure. A synchronous flush kills
// everything the stage holds.
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry. With the
// skid entry, in_ready comes straight from a flop and has no combinational
// path from out_ready. Without it, the stage is a single register and
// in_ready = !main_valid | out_ready.
//
// Occupancy is encoded by the valid bits:
//   EMPTY : main invalid
//   ONE   : main valid, skid empty
//   TWO   : main and skid valid (PIPE_SKID_EN only)
//
// When main is invalid it holds either RESET_VALUE or the last popped
// payload. Consumers must always qualify out_data with out_valid.

module pipe_stage_hs #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic             main_valid_q;
    logic             main_valid_d;
    logic [WIDTH-1:0] main_data_q;
    logic [WIDTH-1:0] main_data_d;

    logic accept;
    logic pop;

    assign accept = in_valid & in_ready;
    assign pop    = main_valid_q & out_ready;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

`ifdef PIPE_SKID_EN

    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;

    // in_ready is a pure flop output, so out_ready never reaches it combinationally
    assign in_ready = !skid_valid_q;
    assign count    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // Next-state for main and skid entries; flush wins over any handshake
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // A pop this cycle is still consumed downstream; an accept is dropped
            main_valid_d = 1'b0;
            main_data_d  = RESET_VALUE;
            skid_valid_d = 1'b0;
            skid_data_d  = RESET_VALUE;
        end else begin
            case ({main_valid_q, skid_valid_q})
                2'b00: begin
                    // EMPTY: an incoming payload goes straight to main
                    if (accept) begin
                        main_valid_d = 1'b1;
                        main_data_d  = in_data;
                    end
                end
                2'b10: begin
                    // ONE: replace on pop+accept, park in skid on accept only
                    if (accept && pop) begin
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = in_data;
                    end else if (pop) begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // TWO: in_ready is low, so only a pop can happen; skid moves up
                    if (pop) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    // Skid valid with main invalid never arises; drop the stray entry
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset clears both entries and reloads RESET_VALUE
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VALUE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= RESET_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

`else

    // A full stage can still accept if its payload leaves in the same cycle
    assign in_ready = !main_valid_q | out_ready;
    assign count    = {1'b0, main_valid_q};

    // Next-state for the single main entry; flush wins over any handshake
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RESET_VALUE;
        end else if (accept) begin
            // Covers both EMPTY + accept and ONE + accept + pop
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (pop) begin
            // Data is left as the popped payload
            main_valid_d = 1'b0;
        end
    end

    // State register; reset clears the entry and reloads RESET_VALUE
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs. It covers reset, streaming, simultaneous
// push/pop, backpressure and flush. It follows PIPE_SKID_EN the same way the
// design does.

module tb_pipe_stage_hs;

    localparam int unsigned      W  = 32;
    localparam logic [W-1:0]     RV = 32'hbfbf_fffc;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int total;
    int bad;

    pipe_stage_hs #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        out_ready = 1'b1;

        // Reset held for two cycles while a payload is offered
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, RV);
        chk("rst_count", {30'b0, count}, 32'd0);

        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("rst_no_55", {31'b0, out_valid}, 32'd0);

        // Streaming 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            tick();
            chk($sformatf("stream_valid_%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stream_data_%0d", i), out_data, i);
            chk($sformatf("stream_count_%0d", i), {30'b0, count}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", {31'b0, out_valid}, 32'd0);
        chk("stream_drain_count", {30'b0, count}, 32'd0);
        chk("stream_drain_data", out_data, 32'd8);

        // Simultaneous push and pop while holding one payload
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        chk("sim_hold_data", out_data, 32'h1);
        chk("sim_hold_count", {30'b0, count}, 32'd1);
        in_data   = 32'h2;
        out_ready = 1'b1;
        tick();
        chk("sim_count", {30'b0, count}, 32'd1);
        chk("sim_data", out_data, 32'h2);
        in_valid = 1'b0;
        tick();
        chk("sim_drain_valid", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_SKID_EN
        // Backpressure: fill both entries, the third payload is held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        chk("bp_one_in_ready", {31'b0, in_ready}, 32'd1);
        in_data = 32'hB;
        tick();
        chk("bp_two_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_two_count", {30'b0, count}, 32'd2);
        in_data = 32'hC;
        tick();
        chk("bp_c_count", {30'b0, count}, 32'd2);
        chk("bp_c_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_c_data_a", out_data, 32'hA);
        // Release: A, B, C on consecutive cycles
        out_ready = 1'b1;
        #1;
        chk("bp_rel_ready_comb", {31'b0, in_ready}, 32'd0);
        tick();
        chk("bp_out_b", out_data, 32'hB);
        chk("bp_out_b_valid", {31'b0, out_valid}, 32'd1);
        tick();
        chk("bp_out_c", out_data, 32'hC);
        chk("bp_out_c_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_drain_count", {30'b0, count}, 32'd0);

        // Flush in TWO with a payload offered in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        chk("fl_pre_count", {30'b0, count}, 32'd2);
        flush   = 1'b1;
        in_data = 32'hD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_count", {30'b0, count}, 32'd0);
        chk("fl_data", out_data, RV);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("fl_after2_valid", {31'b0, out_valid}, 32'd0);
`else
        // Combinational in_ready follows out_ready when main is full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_valid = 1'b0;
        #1;
        chk("nc_full_in_ready", {31'b0, in_ready}, 32'd0);
        chk("nc_full_count", {30'b0, count}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("nc_rel_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = 32'hB;
        tick();
        chk("nc_swap_data", out_data, 32'hB);
        chk("nc_swap_count", {30'b0, count}, 32'd1);

        // Flush while full with a payload offered in the same cycle
        out_ready = 1'b0;
        flush     = 1'b1;
        in_data   = 32'hD;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_count", {30'b0, count}, 32'd0);
        chk("fl_data", out_data, RV);
        chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
`endif

        // Reset in the middle of a held transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h77;
        tick();
        chk("mr_pre_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'd0);
        chk("mr_data", out_data, RV);
        chk("mr_count", {30'b0, count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
